// File: rtl/fat32_cluster_chain_reader.sv
// rtl/fat32_cluster_chain_reader.sv - FAT32 cluster-chain walker emitting absolute data sector numbers
// Walks a file's chain through a one-sector FAT cache and streams every data sector in order.
module fat32_cluster_chain_reader #(
    parameter int unsigned MaxClusters = 65536
) (
    input  logic        Clock,
    input  logic        sys_rst_n,
    input  logic        Start,
    input  logic [31:0] StartCluster,
    input  logic [31:0] FATStartSector,
    input  logic [31:0] DataStartSector,
    input  logic [7:0]  SectorsPerCluster,
    input  logic [31:0] RootClusterNumber,
    output logic        ReadRequest,
    output logic [31:0] ReadSector,
    input  logic        ByteValid,
    input  logic [8:0]  ByteAddress,
    input  logic [7:0]  Byte,
    input  logic        ReadDone,
    output logic        DataSectorValid,
    output logic [31:0] DataSector,
    input  logic        DataSectorReady,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [31:0] ClusterCount
);

    typedef enum logic [3:0] {
        S_IDLE, S_BASE, S_EMIT, S_LOOKUP, S_FATREQ, S_FATRECV, S_CHECK, S_FINISH, S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] base_q, base_d;
    logic [31:0] count_q, count_d;
    logic [31:0] tag_q, tag_d;
    logic [31:0] fat_start_q, fat_start_d;
    logic [31:0] data_start_q, data_start_d;
    logic [31:0] root_q, root_d;
    logic [7:0]  spc_q, spc_d;
    logic [7:0]  k_q, k_d;
    logic        cache_valid_q, cache_valid_d;
    logic [31:0] cache_q [128];

    logic        busy;
    logic        fetching;
    logic [31:0] fat_sector;
    logic [31:0] next_cluster;
    logic [31:0] cur_offset;

    assign busy         = !(state_q inside {S_IDLE, S_FINISH, S_FAIL});
    assign fetching     = (state_q == S_FATREQ) || (state_q == S_FATRECV);
    assign fat_sector   = fat_start_q + (cur_q >> 7);
    assign next_cluster = cache_q[cur_q[6:0]] & 32'h0FFF_FFFF;
    assign cur_offset   = (cur_q - root_q) * {24'd0, spc_q};

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        base_d        = base_q;
        count_d       = count_q;
        tag_d         = tag_q;
        fat_start_d   = fat_start_q;
        data_start_d  = data_start_q;
        root_d        = root_q;
        spc_d         = spc_q;
        k_d           = k_q;
        cache_valid_d = cache_valid_q;

        case (state_q)
            S_BASE: begin
                base_d  = data_start_q + cur_offset;
                k_d     = 8'd0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (DataSectorReady) begin
                    k_d = k_q + 8'd1;
                    if (k_q == spc_q - 8'd1) begin
                        count_d = count_q + 32'd1;
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (cache_valid_q && tag_q == fat_sector) begin
                    state_d = S_CHECK;
                end else begin
                    // Cache contents are about to be overwritten; drop the tag now.
                    cache_valid_d = 1'b0;
                    state_d       = S_FATREQ;
                end
            end
            S_FATREQ, S_FATRECV: begin
                if (state_q == S_FATREQ) state_d = S_FATRECV;
                if (ReadDone) begin
                    tag_d         = fat_sector;
                    cache_valid_d = 1'b1;
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                if (next_cluster >= 32'h0FFF_FFF8) begin
                    state_d = S_FINISH;
                end else if (next_cluster < 32'd2 || next_cluster >= 32'h0FFF_FFF0) begin
                    state_d = S_FAIL;
                end else if (count_q == 32'(MaxClusters)) begin
                    state_d = S_FAIL;
                end else begin
                    cur_d   = next_cluster;
                    state_d = S_BASE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (Start && !busy) begin
            cur_d        = StartCluster;
            count_d      = 32'd0;
            fat_start_d  = FATStartSector;
            data_start_d = DataStartSector;
            root_d       = RootClusterNumber;
            spc_d        = SectorsPerCluster;
            state_d      = (StartCluster < 32'd2 || StartCluster >= 32'h0FFF_FFF0) ? S_FAIL : S_BASE;
        end
    end

    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            cur_q         <= '0;
            base_q        <= '0;
            count_q       <= '0;
            tag_q         <= '0;
            fat_start_q   <= '0;
            data_start_q  <= '0;
            root_q        <= '0;
            spc_q         <= '0;
            k_q           <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            base_q        <= base_d;
            count_q       <= count_d;
            tag_q         <= tag_d;
            fat_start_q   <= fat_start_d;
            data_start_q  <= data_start_d;
            root_q        <= root_d;
            spc_q         <= spc_d;
            k_q           <= k_d;
            cache_valid_q <= cache_valid_d;
        end
    end

    // Little-endian lane placement; bytes outside a fetch never touch the cache.
    always_ff @(posedge Clock) begin
        if (fetching && ByteValid) begin
            cache_q[ByteAddress[8:2]][{ByteAddress[1:0], 3'b000} +: 8] <= Byte;
        end
    end

    assign ReadRequest     = fetching;
    assign ReadSector      = fetching ? fat_sector : 32'd0;
    assign DataSectorValid = (state_q == S_EMIT);
    assign DataSector      = base_q + {24'd0, k_q};
    assign Busy            = busy;
    assign Done            = (state_q == S_FINISH);
    assign Error           = (state_q == S_FAIL);
    assign ClusterCount    = count_q;

endmodule

// File: tb/tb_fat32_cluster_chain_reader.sv
// tb/tb_fat32_cluster_chain_reader.sv - self-checking bench for fat32_cluster_chain_reader
module tb_fat32_cluster_chain_reader;
    typedef logic [31:0] u32_q [$];
    localparam int BUDGET = 20000;

    logic        Clock = 1'b0;
    logic        sys_rst_n;
    logic        Start;
    logic [31:0] StartCluster, FATStartSector, DataStartSector, RootClusterNumber;
    logic [7:0]  SectorsPerCluster;
    logic        ReadRequest;
    logic [31:0] ReadSector;
    logic        ByteValid;
    logic [8:0]  ByteAddress;
    logic [7:0]  Byte;
    logic        ReadDone;
    logic        DataSectorValid;
    logic [31:0] DataSector;
    logic        DataSectorReady;
    logic        Busy, Done, Error;
    logic [31:0] ClusterCount;

    fat32_cluster_chain_reader dut (
        .Clock(Clock), .sys_rst_n(sys_rst_n), .Start(Start), .StartCluster(StartCluster),
        .FATStartSector(FATStartSector), .DataStartSector(DataStartSector),
        .SectorsPerCluster(SectorsPerCluster), .RootClusterNumber(RootClusterNumber),
        .ReadRequest(ReadRequest), .ReadSector(ReadSector), .ByteValid(ByteValid),
        .ByteAddress(ByteAddress), .Byte(Byte), .ReadDone(ReadDone),
        .DataSectorValid(DataSectorValid), .DataSector(DataSector),
        .DataSectorReady(DataSectorReady), .Busy(Busy), .Done(Done), .Error(Error),
        .ClusterCount(ClusterCount)
    );

    always #5 Clock = ~Clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] fat [int];
    logic [31:0] m_cache [128];
    logic        m_valid;
    logic [31:0] m_tag;
    u32_q        exp_sectors, exp_reads, obs_sectors, obs_reads;
    int          exp_done, exp_error;
    logic [31:0] exp_count, obs_count;
    int          obs_done, obs_error, obs_timeout, obs_aborted, obs_hold_viol, obs_rs_viol;
    int          obs_first_valid, obs_first_accept, obs_last_accept;
    logic        obs_busy_start, obs_busy_end;
    int          ready_mode;

    function automatic logic [31:0] fat_get(input int idx);
        return fat.exists(idx) ? fat[idx] : 32'd0;
    endfunction

    function automatic logic [7:0] fat_byte(input logic [31:0] sec, input int idx);
        logic [31:0] e;
        e = fat_get(int'(sec - FATStartSector) * 128 + idx / 4);
        return e[(idx % 4) * 8 +: 8];
    endfunction

    function automatic int q_diff(input u32_q a, input u32_q b);
        int d;
        d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
        return d;
    endfunction

    // Reference walk: follows the chain through a one-sector FAT cache that lives across walks.
    function automatic void model_walk(input logic [31:0] sc);
        logic [31:0] cur, n, fs;
        exp_sectors.delete(); exp_reads.delete();
        exp_done = 0; exp_error = 0; exp_count = 0;
        cur = sc;
        if (cur < 2 || cur >= 32'h0FFFFFF0) begin exp_error = 1; return; end
        while (exp_count < 1000) begin
            for (int k = 0; k < int'(SectorsPerCluster); k++)
                exp_sectors.push_back(DataStartSector + (cur - RootClusterNumber) * {24'd0, SectorsPerCluster} + 32'(k));
            exp_count++;
            fs = FATStartSector + cur / 128;
            if (!m_valid || m_tag != fs) begin
                exp_reads.push_back(fs);
                for (int i = 0; i < 128; i++) m_cache[i] = fat_get(int'(fs - FATStartSector) * 128 + i);
                m_valid = 1; m_tag = fs;
            end
            n = m_cache[cur % 128] & 32'h0FFFFFFF;
            if (n >= 32'h0FFFFFF8) begin exp_done = 1; return; end
            if (n < 2 || n >= 32'h0FFFFFF0) begin exp_error = 1; return; end
            cur = n;
        end
        exp_error = 1;
    endfunction

    task automatic apply_reset();
        sys_rst_n = 0; Start = 0; StartCluster = 0; ByteValid = 0; ByteAddress = 0; Byte = 0;
        ReadDone = 0; DataSectorReady = 0;
        repeat (3) @(negedge Clock);
        sys_rst_n = 1; m_valid = 0;
        @(negedge Clock);
    endtask

    task automatic set_defaults();
        SectorsPerCluster = 8'd8; DataStartSector = 32'h4000; RootClusterNumber = 32'd2;
        FATStartSector = 32'h20; fat.delete(); ready_mode = 0;
    endtask

    // Drives one walk: consumer on DataSector*, FAT sector server on Read*/Byte*; records observations only.
    task automatic run_walk(input logic [31:0] sc, input int abort_bytes);
        int rstate, delay, bidx, tail, stall_left, stall_done;
        logic [31:0] rsec, prev_sector;
        logic prev_pending, r;
        obs_sectors.delete(); obs_reads.delete();
        obs_done = 0; obs_error = 0; obs_timeout = 0; obs_aborted = 0; obs_hold_viol = 0; obs_rs_viol = 0;
        obs_first_valid = -1; obs_first_accept = -1; obs_last_accept = -1; obs_busy_start = 0; obs_busy_end = 1;
        rstate = 0; delay = 0; bidx = 0; tail = 0; stall_left = 0; stall_done = 0;
        rsec = 0; prev_sector = 0; prev_pending = 0;
        @(negedge Clock);
        StartCluster = sc; Start = 1;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge Clock);
            Start = 0;
            if (cyc == 1) obs_busy_start = Busy;
            if (Done === 1'b1) obs_done++;
            if (Error === 1'b1) obs_error++;
            if (prev_pending && (DataSectorValid !== 1'b1 || DataSector !== prev_sector)) obs_hold_viol++;
            if (stall_left > 0) begin r = 0; stall_left--; end
            else if (ready_mode == 1) r = ($urandom_range(0, 3) != 0);
            else r = 1;
            DataSectorReady = r;
            if (DataSectorValid === 1'b1) begin
                if (obs_first_valid < 0) obs_first_valid = cyc;
                if (r) begin
                    obs_sectors.push_back(DataSector);
                    if (obs_first_accept < 0) obs_first_accept = cyc;
                    obs_last_accept = cyc;
                    if (ready_mode == 2 && stall_done == 0 && obs_sectors.size() == 3) begin
                        stall_left = 10; stall_done = 1;
                    end
                end
            end
            prev_pending = (DataSectorValid === 1'b1) && !r;
            prev_sector  = DataSector;
            ByteValid = 0; ReadDone = 0;
            case (rstate)
                0: if (ReadRequest === 1'b1) begin
                    obs_reads.push_back(ReadSector); rsec = ReadSector;
                    delay = $urandom_range(0, 3); bidx = 0; rstate = 1;
                end
                1: begin
                    if (ReadRequest !== 1'b1 || ReadSector !== rsec) obs_rs_viol++;
                    if (delay > 0) delay--;
                    else if ($urandom_range(0, 3) != 0) begin
                        ByteValid = 1; ByteAddress = 9'(bidx); Byte = fat_byte(rsec, bidx);
                        bidx++;
                        if (bidx == abort_bytes) begin obs_aborted = 1; return; end
                        if (bidx == 512) rstate = 2;
                    end
                end
                default: begin
                    if (ReadRequest !== 1'b1 || ReadSector !== rsec) obs_rs_viol++;
                    ReadDone = 1; rstate = 0;
                end
            endcase
            if (tail > 0) begin
                tail--;
                if (tail == 0) begin obs_busy_end = Busy; obs_count = ClusterCount; return; end
            end else if (Done === 1'b1 || Error === 1'b1) tail = 2;
        end
        obs_timeout = 1;
    endtask

    task automatic test_reset();
        sys_rst_n = 0; Start = 0; ByteValid = 0; ReadDone = 0; DataSectorReady = 0;
        StartCluster = 0; ByteAddress = 0; Byte = 0; set_defaults();
        #1;
        n_checks++;
        if ({ReadRequest, ReadSector, DataSectorValid, DataSector, Busy, Done, Error, ClusterCount} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: req=%b sec=%h valid=%b ds=%h busy=%b done=%b err=%b cnt=%0d, required all 0",
                     ReadRequest, ReadSector, DataSectorValid, DataSector, Busy, Done, Error, ClusterCount);
        end
        apply_reset();
    endtask

    task automatic test_single_cluster();
        apply_reset(); set_defaults();
        fat[5] = 32'h0FFFFFFF;
        model_walk(32'd5); run_walk(32'd5, -1);
        n_checks++; if (q_diff(obs_sectors, exp_sectors) != 0 || exp_sectors.size() != 8 || obs_sectors[0] !== 32'h4018) begin n_errors++;
            $display("FAIL single_sectors: got %0d sectors, required 8 from 0x4018 (diff %0d)", obs_sectors.size(), q_diff(obs_sectors, exp_sectors)); end
        n_checks++; if (obs_reads.size() != 1 || obs_reads[0] !== 32'h20) begin n_errors++;
            $display("FAIL single_reads: got %0d reads, required 1 read of 0x20", obs_reads.size()); end
        n_checks++; if (obs_done !== 1 || obs_error !== 0 || obs_timeout !== 0) begin n_errors++;
            $display("FAIL single_done: done=%0d err=%0d timeout=%0d, required 1 0 0", obs_done, obs_error, obs_timeout); end
        n_checks++; if (obs_count !== 32'd1) begin n_errors++;
            $display("FAIL single_count: got %0d, required 1", obs_count); end
        n_checks++; if (obs_first_valid !== 2 || obs_last_accept - obs_first_accept !== 7) begin n_errors++;
            $display("FAIL single_timing: first valid cyc %0d span %0d, required 2 and 7", obs_first_valid, obs_last_accept - obs_first_accept); end
        n_checks++; if (obs_busy_start !== 1'b1 || obs_busy_end !== 1'b0 || obs_rs_viol !== 0) begin n_errors++;
            $display("FAIL single_busy: start=%b end=%b rsviol=%0d, required 1 0 0", obs_busy_start, obs_busy_end, obs_rs_viol); end
    endtask

    task automatic test_chain_cache_hit();
        apply_reset(); set_defaults(); ready_mode = 1;
        fat[5] = 32'd6; fat[6] = 32'h0FFFFFFF;
        model_walk(32'd5); run_walk(32'd5, -1);
        n_checks++; if (q_diff(obs_sectors, exp_sectors) != 0 || exp_sectors.size() != 16 || exp_sectors[15] !== 32'h4027) begin n_errors++;
            $display("FAIL chain_sectors: got %0d sectors, required 16 (diff %0d)", obs_sectors.size(), q_diff(obs_sectors, exp_sectors)); end
        n_checks++; if (obs_reads.size() != 1) begin n_errors++;
            $display("FAIL chain_reads: got %0d FAT reads, required 1", obs_reads.size()); end
        n_checks++; if (obs_done !== 1 || obs_error !== 0 || obs_count !== 32'd2 || obs_hold_viol !== 0) begin n_errors++;
            $display("FAIL chain_end: done=%0d err=%0d cnt=%0d hold=%0d, required 1 0 2 0", obs_done, obs_error, obs_count, obs_hold_viol); end
    endtask

    task automatic test_cache_persist();
        // Stray zero bytes while no read is outstanding must leave the cached FAT sector intact.
        for (int i = 0; i < 512; i++) begin
            @(negedge Clock); ByteValid = 1; ByteAddress = 9'(i); Byte = 8'h00;
        end
        @(negedge Clock); ByteValid = 0;
        ready_mode = 0;
        model_walk(32'd5); run_walk(32'd5, -1);
        n_checks++; if (obs_reads.size() != 0 || exp_reads.size() != 0) begin n_errors++;
            $display("FAIL persist_reads: got %0d FAT reads, required 0", obs_reads.size()); end
        n_checks++; if (q_diff(obs_sectors, exp_sectors) != 0 || obs_done !== 1 || obs_error !== 0) begin n_errors++;
            $display("FAIL persist_walk: %0d sectors done=%0d err=%0d, required %0d sectors done=1 err=0", obs_sectors.size(), obs_done, obs_error, exp_sectors.size()); end
    endtask

    task automatic test_sector_cross();
        apply_reset(); set_defaults();
        fat[32'h7F] = 32'h80; fat[32'h80] = 32'hFFFFFFFF;
        model_walk(32'h7F); run_walk(32'h7F, -1);
        n_checks++; if (obs_reads.size() != 2 || q_diff(obs_reads, exp_reads) != 0 || exp_reads[1] !== 32'h21) begin n_errors++;
            $display("FAIL cross_reads: got %0d reads, required 0x20 then 0x21", obs_reads.size()); end
        n_checks++; if (q_diff(obs_sectors, exp_sectors) != 0 || obs_done !== 1 || obs_count !== 32'd2) begin n_errors++;
            $display("FAIL cross_walk: %0d sectors done=%0d cnt=%0d, required %0d sectors done=1 cnt=2", obs_sectors.size(), obs_done, obs_count, exp_sectors.size()); end
    endtask

    task automatic test_ready_stall();
        apply_reset(); set_defaults(); ready_mode = 2;
        fat[5] = 32'd6; fat[6] = 32'h0FFFFFF8;
        model_walk(32'd5); run_walk(32'd5, -1);
        n_checks++; if (obs_hold_viol !== 0) begin n_errors++;
            $display("FAIL stall_hold: %0d cycles with Valid/DataSector not held, required 0", obs_hold_viol); end
        n_checks++; if (q_diff(obs_sectors, exp_sectors) != 0 || obs_count !== 32'd2 || obs_done !== 1) begin n_errors++;
            $display("FAIL stall_sectors: %0d sectors cnt=%0d done=%0d, required %0d cnt=2 done=1", obs_sectors.size(), obs_count, obs_done, exp_sectors.size()); end
    endtask

    task automatic test_errors();
        logic [31:0] bad_entry [2] = '{32'h0FFFFFF7, 32'h00000000};
        for (int i = 0; i < 2; i++) begin
            apply_reset(); set_defaults();
            fat[5] = bad_entry[i];
            model_walk(32'd5); run_walk(32'd5, -1);
            n_checks++; if (obs_error !== 1 || obs_done !== 0 || obs_sectors.size() != 8 || q_diff(obs_sectors, exp_sectors) != 0 || obs_count !== 32'd1) begin n_errors++;
                $display("FAIL err_entry_%h: err=%0d done=%0d sectors=%0d cnt=%0d, required 1 0 8 1", bad_entry[i], obs_error, obs_done, obs_sectors.size(), obs_count); end
        end
        for (int i = 0; i < 2; i++) begin
            logic [31:0] sc;
            sc = (i == 0) ? 32'd1 : 32'h0FFFFFF0;
            model_walk(sc); run_walk(sc, -1);
            n_checks++; if (obs_error !== exp_error || obs_done !== 0 || obs_sectors.size() != 0 || obs_reads.size() != 0 || obs_count !== 32'd0) begin n_errors++;
                $display("FAIL err_start_%h: err=%0d done=%0d sectors=%0d reads=%0d cnt=%0d, required 1 0 0 0 0", sc, obs_error, obs_done, obs_sectors.size(), obs_reads.size(), obs_count); end
        end
    endtask

    task automatic test_reset_midwalk();
        apply_reset(); set_defaults();
        fat[5] = 32'h0FFFFFFF;
        run_walk(32'd5, 100);
        #2 sys_rst_n = 0;
        #1;
        n_checks++; if (obs_aborted !== 1 || {ReadRequest, ReadSector, DataSectorValid, DataSector, Busy, Done, Error, ClusterCount} !== '0) begin n_errors++;
            $display("FAIL midreset_outputs: aborted=%0d req=%b busy=%b cnt=%0d, required aborted and all outputs 0", obs_aborted, ReadRequest, Busy, ClusterCount); end
        ByteValid = 0;
        repeat (2) @(negedge Clock);
        sys_rst_n = 1; m_valid = 0;
        model_walk(32'd5); run_walk(32'd5, -1);
        n_checks++; if (obs_reads.size() != 1 || q_diff(obs_reads, exp_reads) != 0 || obs_done !== 1 || q_diff(obs_sectors, exp_sectors) != 0) begin n_errors++;
            $display("FAIL midreset_reread: reads=%0d done=%0d sectors=%0d, required 1 read of 0x20, done, 8 sectors", obs_reads.size(), obs_done, obs_sectors.size()); end
    endtask

    task automatic test_random();
        apply_reset(); set_defaults(); FATStartSector = 32'h100;
        for (int w = 0; w < 12; w++) begin
            logic [31:0] cl [$];
            logic [31:0] c;
            logic [3:0]  nib;
            int len, kind, dup;
            SectorsPerCluster = 8'(1 << $urandom_range(0, 3));
            RootClusterNumber = 32'($urandom_range(2, 4));
            DataStartSector   = $urandom;
            ready_mode        = $urandom_range(0, 1);
            len = $urandom_range(1, 4);
            cl.delete();
            while (cl.size() < len) begin
                c = 32'(w * 512 + $urandom_range(2, 383)); dup = 0;
                foreach (cl[j]) if (cl[j] == c) dup = 1;
                if (dup == 0) cl.push_back(c);
            end
            for (int i = 0; i < len - 1; i++) begin
                nib = 4'($urandom_range(0, 15)); c = cl[i + 1];
                fat[int'(cl[i])] = {nib, c[27:0]};
            end
            nib = 4'($urandom_range(0, 15)); kind = $urandom_range(0, 9);
            if (kind == 7)      fat[int'(cl[len - 1])] = {nib, 28'hFFFFFF0 + 28'($urandom_range(0, 7))};
            else if (kind == 8) fat[int'(cl[len - 1])] = {nib, 28'($urandom_range(0, 1))};
            else                fat[int'(cl[len - 1])] = {nib, 28'hFFFFFF8 + 28'($urandom_range(0, 7))};
            model_walk(cl[0]); run_walk(cl[0], -1);
            n_checks++; if (q_diff(obs_sectors, exp_sectors) != 0 || q_diff(obs_reads, exp_reads) != 0) begin n_errors++;
                $display("FAIL random_%0d_stream: sectors %0d/%0d reads %0d/%0d (got/required)", w, obs_sectors.size(), exp_sectors.size(), obs_reads.size(), exp_reads.size()); end
            n_checks++; if (obs_done !== exp_done || obs_error !== exp_error || obs_count !== exp_count || obs_timeout !== 0 || obs_hold_viol !== 0 || obs_rs_viol !== 0) begin n_errors++;
                $display("FAIL random_%0d_end: done=%0d err=%0d cnt=%0d timeout=%0d hold=%0d rs=%0d, required done=%0d err=%0d cnt=%0d 0 0 0",
                         w, obs_done, obs_error, obs_count, obs_timeout, obs_hold_viol, obs_rs_viol, exp_done, exp_error, exp_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single_cluster();
        test_chain_cache_hit();
        test_cache_persist();
        test_sector_cross();
        test_ready_stall();
        test_errors();
        test_reset_midwalk();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
